// File: rtl/img_capture.sv
`timescale 1ns/1ps
// img_capture: pixel-bus capture stage on the sensor pixel clock.
// Frames exactly one complete sensor frame per capture request and streams
// its pixels through a single-entry valid/ready output register.
// Geometry errors (line width, line count, excess pixels) and output
// overflow are reported as sticky flags.
// Optional macro IMG_CAPTURE_STATS_EN adds highlight/shadow pixel counters;
// without it both statistics outputs are tied to zero.

module img_capture #(
   parameter int          ImgWidth           = 256,
   parameter int          ImgHeight          = 256,
   parameter logic [11:0] HighlightThreshold = 12'hF00,
   parameter logic [11:0] ShadowThreshold    = 12'h0FF
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic [11:0] img_d,
   input  logic        img_fv,
   input  logic        img_lv,
   input  logic        cap_trigger,
   output logic        cap_busy,
   output logic        cap_done,
   output logic        cap_ok,
   output logic        cap_overflow,
   output logic        cap_size_err,
   output logic [31:0] cap_pixel_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_first,
   output logic        out_last,
   output logic [31:0] cap_highlight_count,
   output logic [31:0] cap_shadow_count
);

   localparam logic [31:0] FRAME_PIX   = 32'(ImgWidth * ImgHeight);
   localparam logic [31:0] LINE_PIX    = 32'(ImgWidth);
   localparam logic [31:0] FRAME_LINES = 32'(ImgHeight);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      WAIT_FRAME,
      CAPTURE,
      DONE
   } state_e;

   state_e      state_q, state_d;

   logic [11:0] img_d_p1_q;
   logic        fv_p1_q, lv_p1_q;
   logic        fv_p2_q, act_p2_q;

   logic        act_p1, fv_rise, fv_fall, line_end;
   logic        accept, capturing, finish;
   logic        pix, emit, excess, out_take, load, drop, lend;
   logic        width_bad, height_bad;

   logic [31:0] cnt_q, cnt_d, col_q, col_d, row_q, row_d, row_next;
   logic        busy_q, busy_d, done_q, done_d, ok_q, ok_d;
   logic        ovf_q, ovf_d, err_q, err_d;

   logic        out_valid_q, out_valid_d;
   logic        out_first_q, out_first_d;
   logic        out_last_q, out_last_d;
   logic [11:0] out_px_q, out_px_d;

   // Stage S1: register the raw sensor bus once; keep previous S1 for edges
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         img_d_p1_q <= '0;
         fv_p1_q    <= 1'b0;
         lv_p1_q    <= 1'b0;
         fv_p2_q    <= 1'b0;
         act_p2_q   <= 1'b0;
      end else begin
         img_d_p1_q <= img_d;
         fv_p1_q    <= img_fv;
         lv_p1_q    <= img_lv;
         fv_p2_q    <= fv_p1_q;
         act_p2_q   <= fv_p1_q & lv_p1_q;
      end
   end

   // A line is "active" only inside a frame, so an lv still high when fv
   // drops ends the line in the same cycle as the frame.
   assign act_p1   = fv_p1_q & lv_p1_q;
   assign fv_rise  = fv_p1_q & ~fv_p2_q;
   assign fv_fall  = ~fv_p1_q & fv_p2_q;
   assign line_end = act_p2_q & ~act_p1;

   // Capture sequencer state register
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Capture sequencer next state and control strobes
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      capturing = 1'b0;
      finish    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cap_trigger) begin
               state_d = ARMED;
               accept  = 1'b1;
            end
         end
         ARMED: begin
            // never start inside a frame that is already running
            if (!fv_p1_q) state_d = WAIT_FRAME;
         end
         WAIT_FRAME: begin
            if (fv_rise) begin
               state_d   = CAPTURE;
               capturing = 1'b1;
            end
         end
         CAPTURE: begin
            capturing = 1'b1;
            if (fv_fall) begin
               state_d = DONE;
               finish  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel accounting, geometry checks, status flags and output register load
   always_comb begin
      pix      = capturing & act_p1;
      emit     = pix & (cnt_q < FRAME_PIX);
      excess   = pix & ~emit;
      out_take = ~out_valid_q | out_ready;
      load     = emit & out_take;
      drop     = emit & ~out_take;
      lend     = capturing & line_end;

      width_bad  = lend & (col_q != LINE_PIX);
      row_next   = lend ? row_q + 32'd1 : row_q;
      height_bad = finish & (row_next != FRAME_LINES);

      cnt_d  = cnt_q;
      col_d  = col_q;
      row_d  = row_q;
      busy_d = busy_q;
      ok_d   = ok_q;
      ovf_d  = ovf_q;
      err_d  = err_q;
      done_d = finish;

      if (accept) begin
         cnt_d  = '0;
         col_d  = '0;
         row_d  = '0;
         busy_d = 1'b1;
         ok_d   = 1'b0;
         ovf_d  = 1'b0;
         err_d  = 1'b0;
      end else begin
         cnt_d = cnt_q + {31'd0, pix};
         col_d = lend ? 32'd0 : col_q + {31'd0, pix};
         row_d = row_next;
         ovf_d = ovf_q | drop;
         err_d = err_q | excess | width_bad | height_bad;
         if (finish) begin
            busy_d = 1'b0;
            ok_d   = ~ovf_d & ~err_d;
         end
      end

      out_valid_d = out_valid_q;
      out_px_d    = out_px_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_px_d    = img_d_p1_q;
         out_first_d = (cnt_q == 32'd0);
         out_last_d  = (cnt_q == FRAME_PIX - 32'd1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_first_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // Status, counters and output register state
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cnt_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ok_q        <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_px_q    <= '0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ok_q        <= ok_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_px_q    <= out_px_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
      end
   end

   assign cap_busy        = busy_q;
   assign cap_done        = done_q;
   assign cap_ok          = ok_q;
   assign cap_overflow    = ovf_q;
   assign cap_size_err    = err_q;
   assign cap_pixel_count = cnt_q;
   assign out_valid       = out_valid_q;
   assign out_data        = {4'b0000, out_px_q};
   assign out_first       = out_first_q;
   assign out_last        = out_last_q;

`ifdef IMG_CAPTURE_STATS_EN
   logic [31:0] hl_q, hl_d, sh_q, sh_d;

   // Highlight/shadow counts over emitted pixels (dropped ones included)
   always_comb begin
      hl_d = hl_q;
      sh_d = sh_q;
      if (accept) begin
         hl_d = '0;
         sh_d = '0;
      end else if (emit) begin
         if (img_d_p1_q >= HighlightThreshold) hl_d = hl_q + 32'd1;
         if (img_d_p1_q <= ShadowThreshold)    sh_d = sh_q + 32'd1;
      end
   end

   // Statistics counter registers
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         hl_q <= '0;
         sh_q <= '0;
      end else begin
         hl_q <= hl_d;
         sh_q <= sh_d;
      end
   end

   assign cap_highlight_count = hl_q;
   assign cap_shadow_count    = sh_q;
`else
   assign cap_highlight_count = '0;
   assign cap_shadow_count    = '0;
`endif

endmodule

// File: tb/tb_img_capture.sv
`timescale 1ns/1ps
// Self-checking bench for img_capture on a 4x2 frame geometry.
// Frames are described as a list of line widths plus the pixel values in
// raster order; expectations come from frame-level rules applied to that list.

module tb_img_capture;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int WH = W * H;

   logic        clk = 1'b0;
   logic        rst_;
   logic [11:0] img_d;
   logic        img_fv, img_lv, cap_trigger, out_ready;
   logic        cap_busy, cap_done, cap_ok, cap_overflow, cap_size_err;
   logic [31:0] cap_pixel_count, cap_highlight_count, cap_shadow_count;
   logic        out_valid, out_first, out_last;
   logic [15:0] out_data;

   int          checks = 0;
   int          errors = 0;
   int          line_w[$];
   logic [11:0] px_vals[$];
   int          ready_mode = 0;
   int          done_cnt = 0;
   logic [15:0] rx_d[$];
   logic        rx_f[$];
   logic        rx_l[$];

   img_capture #(.ImgWidth(W), .ImgHeight(H)) dut (
      .clk                 (clk),
      .rst_                (rst_),
      .img_d               (img_d),
      .img_fv              (img_fv),
      .img_lv              (img_lv),
      .cap_trigger         (cap_trigger),
      .cap_busy            (cap_busy),
      .cap_done            (cap_done),
      .cap_ok              (cap_ok),
      .cap_overflow        (cap_overflow),
      .cap_size_err        (cap_size_err),
      .cap_pixel_count     (cap_pixel_count),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .out_first           (out_first),
      .out_last            (out_last),
      .cap_highlight_count (cap_highlight_count),
      .cap_shadow_count    (cap_shadow_count)
   );

   always #5 clk = ~clk;

   // Record accepted output beats and done pulses mid-cycle
   always @(negedge clk) begin
      if (rst_ === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         rx_d.push_back(out_data);
         rx_f.push_back(out_first);
         rx_l.push_back(out_last);
      end
      if (cap_done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic clear_rx();
      rx_d.delete();
      rx_f.delete();
      rx_l.delete();
   endtask

   task automatic fill_inv();
      int n;
      n = 0;
      foreach (line_w[l]) n += line_w[l];
      px_vals.delete();
      for (int i = 0; i < n; i++) px_vals.push_back(~12'(i));
   endtask

   task automatic set_lines(input int a, input int b, input int c);
      line_w.delete();
      if (a > 0) line_w.push_back(a);
      if (b > 0) line_w.push_back(b);
      if (c > 0) line_w.push_back(c);
   endtask

   task automatic trigger();
      tick(); cap_trigger = 1'b1;
      tick(); cap_trigger = 1'b0;
      tick();
      tick();
   endtask

   task automatic drive_frame(input int trig_at);
      int k;
      k = 0;
      tick(); img_fv = 1'b1; img_lv = 1'b0;
      tick();
      for (int l = 0; l < line_w.size(); l++) begin
         for (int j = 0; j < line_w[l]; j++) begin
            tick();
            img_lv = 1'b1;
            img_d = px_vals[k];
            cap_trigger = (k == trig_at);
            k++;
         end
         tick(); img_lv = 1'b0; cap_trigger = 1'b0;
         tick();
      end
      tick(); img_fv = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_done(input int done0);
      int n;
      n = 0;
      while (done_cnt == done0 && n < 40) begin tick(); n++; end
      checks++;
      if (done_cnt == done0) begin
         errors++;
         $display("FAIL done_timeout: got no cap_done within 40 cycles, expected one");
      end
   endtask

   task automatic drain();
      int n;
      ready_mode = 0;
      n = 0;
      tick();
      while (out_valid === 1'b1 && n < 40) begin tick(); n++; end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_ = 1'b0; img_d = '0; img_fv = 1'b0; img_lv = 1'b0;
      cap_trigger = 1'b0; out_ready = 1'b1; ready_mode = 0;
      tick(); tick(); tick();
      checks++;
      if ({cap_busy, cap_done, cap_ok, cap_overflow, cap_size_err, out_valid, out_first, out_last} !== 8'h00) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000000",
                  {cap_busy, cap_done, cap_ok, cap_overflow, cap_size_err, out_valid, out_first, out_last});
      end
      checks++;
      if (cap_pixel_count !== 32'd0 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: count %0d data %h expected 0 0", cap_pixel_count, out_data);
      end
      checks++;
      if (cap_highlight_count !== 32'd0 || cap_shadow_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats: got %0d/%0d expected 0/0", cap_highlight_count, cap_shadow_count);
      end
      rst_ = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [11:0] e;
      int d0;
      set_lines(4, 4, 0); fill_inv(); clear_rx(); ready_mode = 0;
      trigger();
      checks++;
      if (cap_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", cap_busy); end
      d0 = done_cnt;
      drive_frame(-1); wait_done(d0); drain();
      checks++;
      if (rx_d.size() != WH) begin errors++; $display("FAIL basic_len: got %0d expected %0d", rx_d.size(), WH); end
      for (int i = 0; i < rx_d.size(); i++) begin
         e = ~12'(i);
         checks++;
         if (rx_d[i] !== {4'h0, e} || rx_f[i] !== (i == 0) || rx_l[i] !== (i == WH - 1)) begin
            errors++;
            $display("FAIL basic_px%0d: got %h f%b l%b expected %h f%b l%b",
                     i, rx_d[i], rx_f[i], rx_l[i], {4'h0, e}, (i == 0), (i == WH - 1));
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
      checks++;
      if ({cap_ok, cap_busy, cap_overflow, cap_size_err} !== 4'b1000 || cap_pixel_count !== 32'd8) begin
         errors++;
         $display("FAIL basic_status: ok/busy/ovf/err %b count %0d expected 1000 8",
                  {cap_ok, cap_busy, cap_overflow, cap_size_err}, cap_pixel_count);
      end
   endtask

   task automatic test_mid_trigger();
      int d0;
      set_lines(4, 4, 0); clear_rx(); ready_mode = 0;
      px_vals.delete();
      for (int i = 0; i < WH; i++) px_vals.push_back(12'h100 + 12'(i));
      d0 = done_cnt;
      drive_frame(5);
      checks++;
      if (rx_d.size() != 0 || cap_busy !== 1'b1 || done_cnt != d0) begin
         errors++;
         $display("FAIL mid_partial: got %0d beats busy %b done %0d expected 0 beats busy 1 done 0",
                  rx_d.size(), cap_busy, done_cnt - d0);
      end
      fill_inv();
      drive_frame(-1); wait_done(d0); drain();
      checks++;
      if (rx_d.size() != WH || rx_d[0] !== 16'h0FFF || rx_d[WH - 1] !== 16'h0FF8 || rx_f[0] !== 1'b1 || rx_l[WH - 1] !== 1'b1) begin
         errors++;
         $display("FAIL mid_frame: got %0d beats expected %0d starting 0FFF ending 0FF8 with first/last", rx_d.size(), WH);
      end
      checks++;
      if (cap_ok !== 1'b1 || cap_pixel_count !== 32'd8 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL mid_status: ok %b count %0d done %0d expected 1 8 1", cap_ok, cap_pixel_count, done_cnt - d0);
      end
   endtask

   task automatic test_no_ready();
      int d0;
      set_lines(4, 4, 0); fill_inv(); clear_rx(); ready_mode = 0;
      trigger();
      ready_mode = 1;
      tick();
      d0 = done_cnt;
      drive_frame(-1); wait_done(d0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0FFF || out_first !== 1'b1 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL noready_hold: valid %b data %h first %b last %b expected 1 0FFF 1 0",
                  out_valid, out_data, out_first, out_last);
      end
      checks++;
      if (cap_overflow !== 1'b1 || cap_ok !== 1'b0 || cap_size_err !== 1'b0 || cap_pixel_count !== 32'd8) begin
         errors++;
         $display("FAIL noready_status: ovf %b ok %b err %b count %0d expected 1 0 0 8",
                  cap_overflow, cap_ok, cap_size_err, cap_pixel_count);
      end
      drain();
      checks++;
      if (rx_d.size() != 1 || rx_d[0] !== 16'h0FFF) begin
         errors++;
         $display("FAIL noready_drain: got %0d beats expected 1 beat of 0FFF", rx_d.size());
      end
   endtask

   task automatic test_size_err();
      int d0, n, e_n;
      logic [11:0] e;
      for (int c = 0; c < 2; c++) begin
         if (c == 0) set_lines(4, 3, 0); else set_lines(4, 4, 4);
         n = (c == 0) ? 7 : 12;
         e_n = (n < WH) ? n : WH;
         fill_inv(); clear_rx(); ready_mode = 0;
         trigger();
         d0 = done_cnt;
         drive_frame(-1); wait_done(d0); drain();
         checks++;
         if (cap_size_err !== 1'b1 || cap_ok !== 1'b0 || cap_overflow !== 1'b0 || cap_pixel_count !== 32'(n)) begin
            errors++;
            $display("FAIL size%0d_status: err %b ok %b ovf %b count %0d expected 1 0 0 %0d",
                     c, cap_size_err, cap_ok, cap_overflow, cap_pixel_count, n);
         end
         checks++;
         if (rx_d.size() != e_n) begin
            errors++;
            $display("FAIL size%0d_len: got %0d beats expected %0d", c, rx_d.size(), e_n);
         end else begin
            e = ~12'(e_n - 1);
            checks++;
            if (rx_d[e_n - 1] !== {4'h0, e} || rx_l[e_n - 1] !== (e_n == WH)) begin
               errors++;
               $display("FAIL size%0d_tail: got %h last %b expected %h last %b",
                        c, rx_d[e_n - 1], rx_l[e_n - 1], {4'h0, e}, (e_n == WH));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      set_lines(4, 4, 0); fill_inv(); clear_rx(); ready_mode = 0;
      trigger();
      d0 = done_cnt;
      tick(); img_fv = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) begin tick(); img_lv = 1'b1; img_d = px_vals[j]; end
      #1 rst_ = 1'b0;
      #1;
      checks++;
      if ({cap_busy, cap_ok, cap_overflow, cap_size_err, out_valid, out_first} !== 6'b0 ||
          cap_pixel_count !== 32'd0 || out_data !== 16'h0000) begin
         errors++;
         $display("FAIL rstmid_clear: flags %b count %0d data %h expected 000000 0 0000",
                  {cap_busy, cap_ok, cap_overflow, cap_size_err, out_valid, out_first}, cap_pixel_count, out_data);
      end
      tick(); img_lv = 1'b0; img_fv = 1'b0;
      tick(); tick();
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done: got %0d pulses expected 0", done_cnt - d0); end
      rst_ = 1'b1;
      tick();
      clear_rx();
      trigger();
      d0 = done_cnt;
      drive_frame(-1); wait_done(d0); drain();
      checks++;
      if (rx_d.size() != WH || cap_ok !== 1'b1 || cap_pixel_count !== 32'd8 || rx_d[0] !== 16'h0FFF) begin
         errors++;
         $display("FAIL rstmid_recap: beats %0d ok %b count %0d expected 8 1 8", rx_d.size(), cap_ok, cap_pixel_count);
      end
   endtask

   task automatic test_stats();
      int d0, e_hl, e_sh;
      set_lines(4, 4, 0); clear_rx(); ready_mode = 0;
      px_vals.delete();
      for (int i = 0; i < WH; i++) px_vals.push_back((i % 2 == 0) ? 12'hFFF : 12'h000);
`ifdef IMG_CAPTURE_STATS_EN
      e_hl = 4; e_sh = 4;
`else
      e_hl = 0; e_sh = 0;
`endif
      trigger();
      d0 = done_cnt;
      drive_frame(-1); wait_done(d0); drain();
      checks++;
      if (cap_highlight_count !== 32'(e_hl) || cap_shadow_count !== 32'(e_sh) || cap_ok !== 1'b1) begin
         errors++;
         $display("FAIL stats_alt: hl %0d sh %0d ok %b expected %0d %0d 1",
                  cap_highlight_count, cap_shadow_count, cap_ok, e_hl, e_sh);
      end
   endtask

   task automatic test_random();
      int d0, nl, n, e_n, rm, prev, idx, e_hl, e_sh;
      logic e_err, e_ovf;
      logic [11:0] v;
      for (int f = 0; f < 10; f++) begin
         line_w.delete();
         if ($urandom_range(0, 1) == 1) begin
            line_w.push_back(W); line_w.push_back(W);
         end else begin
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) line_w.push_back($urandom_range(2, 6));
         end
         rm = $urandom_range(0, 2);
         n = 0; e_err = (line_w.size() != H);
         foreach (line_w[l]) begin n += line_w[l]; if (line_w[l] != W) e_err = 1'b1; end
         if (n > WH) e_err = 1'b1;
         e_n = (n < WH) ? n : WH;
         if (rm == 0) begin
            px_vals.delete();
            for (int i = 0; i < n; i++) px_vals.push_back(12'($urandom));
         end else begin
            fill_inv();
         end
         e_hl = 0; e_sh = 0;
`ifdef IMG_CAPTURE_STATS_EN
         for (int i = 0; i < e_n; i++) begin
            if (px_vals[i] >= 12'hF00) e_hl++;
            if (px_vals[i] <= 12'h0FF) e_sh++;
         end
`endif
         clear_rx(); ready_mode = 0;
         trigger();
         ready_mode = rm;
         d0 = done_cnt;
         drive_frame(-1); wait_done(d0); drain();
         if (rm == 0) begin
            e_ovf = 1'b0;
            checks++;
            if (rx_d.size() != e_n) begin
               errors++;
               $display("FAIL rnd%0d_len: got %0d beats expected %0d", f, rx_d.size(), e_n);
            end else begin
               for (int i = 0; i < e_n; i++) begin
                  checks++;
                  if (rx_d[i] !== {4'h0, px_vals[i]} || rx_f[i] !== (i == 0) || rx_l[i] !== (i == WH - 1)) begin
                     errors++;
                     $display("FAIL rnd%0d_px%0d: got %h f%b l%b expected %h f%b l%b", f, i,
                              rx_d[i], rx_f[i], rx_l[i], {4'h0, px_vals[i]}, (i == 0), (i == WH - 1));
                  end
               end
            end
         end else if (rm == 1) begin
            e_ovf = (e_n > 1);
            checks++;
            if (rx_d.size() != 1 || rx_d[0] !== {4'h0, px_vals[0]} || rx_f[0] !== 1'b1) begin
               errors++;
               $display("FAIL rnd%0d_hold: got %0d beats expected 1 beat %h first", f, rx_d.size(), {4'h0, px_vals[0]});
            end
         end else begin
            e_ovf = (rx_d.size() != e_n);
            prev = -1;
            for (int i = 0; i < rx_d.size(); i++) begin
               v = ~rx_d[i][11:0];
               idx = int'(v);
               checks++;
               if (!(idx > prev && idx < e_n && rx_d[i][15:12] == 4'h0 &&
                     rx_f[i] == (idx == 0) && rx_l[i] == (idx == WH - 1))) begin
                  errors++;
                  $display("FAIL rnd%0d_seq%0d: got index %0d f%b l%b after %0d expected increasing index below %0d",
                           f, i, idx, rx_f[i], rx_l[i], prev, e_n);
               end
               prev = idx;
            end
         end
         checks++;
         if (cap_overflow !== e_ovf || cap_size_err !== e_err || cap_ok !== (!e_ovf && !e_err) ||
             cap_pixel_count !== 32'(n) || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rnd%0d_status: ovf %b err %b ok %b count %0d done %0d expected %b %b %b %0d 1",
                     f, cap_overflow, cap_size_err, cap_ok, cap_pixel_count, done_cnt - d0,
                     e_ovf, e_err, (!e_ovf && !e_err), n);
         end
         checks++;
         if (cap_highlight_count !== 32'(e_hl) || cap_shadow_count !== 32'(e_sh)) begin
            errors++;
            $display("FAIL rnd%0d_stats: got %0d/%0d expected %0d/%0d",
                     f, cap_highlight_count, cap_shadow_count, e_hl, e_sh);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mid_trigger();
      test_no_ready();
      test_size_err();
      test_reset_mid();
      test_stats();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
